// File: rtl/stereo_sample_fifo_pkg.sv
// -----------------------------------------------------------------------------
// stereo_sample_fifo_pkg
//
// Shared audio definitions used by the stereo sample buffer and its
// neighbours in the audio path.
//
//   AUDIO_DW        default sample width of one channel (24 bits)
//   stereo_frame_t  one stereo frame, left sample in the upper half
//   fifo_state_t    buffer FSM states: idle, prefilling, streaming
// -----------------------------------------------------------------------------
package stereo_sample_fifo_pkg;

    localparam int AUDIO_DW = 24;

    typedef struct packed {
        logic [AUDIO_DW-1:0] left;
        logic [AUDIO_DW-1:0] right;
    } stereo_frame_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2
    } fifo_state_t;

    // Packs a left/right pair into one frame word.
    function automatic stereo_frame_t make_frame(input logic [AUDIO_DW-1:0] left,
                                                 input logic [AUDIO_DW-1:0] right);
        stereo_frame_t f;
        f.left  = left;
        f.right = right;
        return f;
    endfunction

endpackage

// File: rtl/stereo_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// stereo_sample_fifo_if
//
// Sample path between the audio output mux, the stereo buffer and the
// PCM-to-I2S converter.
//
//   l_din_valid / l_din   left sample strobe and data from the mux
//   r_din_valid / r_din   right sample strobe and data from the mux
//   rd_req                frame request from the I2S side
//   dout_valid            one-cycle strobe, l_dout / r_dout carry a frame
//   l_dout / r_dout       frame returned to the I2S side
//
// master: the environment (mux + I2S converter) driving the buffer
// slave : the buffer itself
// -----------------------------------------------------------------------------
interface stereo_sample_fifo_if
    import stereo_sample_fifo_pkg::*;
#(
    parameter int DW = AUDIO_DW
);

    logic          l_din_valid;
    logic          r_din_valid;
    logic [DW-1:0] l_din;
    logic [DW-1:0] r_din;
    logic          rd_req;
    logic          dout_valid;
    logic [DW-1:0] l_dout;
    logic [DW-1:0] r_dout;

    modport master (
        output l_din_valid,
        output r_din_valid,
        output l_din,
        output r_din,
        output rd_req,
        input  dout_valid,
        input  l_dout,
        input  r_dout
    );

    modport slave (
        input  l_din_valid,
        input  r_din_valid,
        input  l_din,
        input  r_din,
        input  rd_req,
        output dout_valid,
        output l_dout,
        output r_dout
    );

endinterface

// File: rtl/stereo_sample_fifo_ram.sv
// -----------------------------------------------------------------------------
// stereo_frame_ram
//
// Simple dual-port DEPTH x W memory holding stereo frames. Writes and reads
// are both synchronous; the read data is registered and only updates when
// rd_en is high, so it holds the last popped frame.
//
//   clk      system clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  frame to store
//   rd_en    read strobe
//   rd_addr  read address
//   rd_data  registered read data, valid the cycle after rd_en
//
// A read and a write to the same address in one cycle return the old
// contents. The top relies on this when a write and a pop collide on a
// full buffer, where wr_ptr equals rd_ptr.
// -----------------------------------------------------------------------------
module stereo_frame_ram
    import stereo_sample_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 2 * AUDIO_DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // No reset on storage or the read register so the tools can map this
    // onto LUTRAM or block RAM; the top masks rd_data until the first pop.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stereo_sample_fifo.sv
// -----------------------------------------------------------------------------
// stereo_sample_fifo
//
// Elastic stereo buffer between the audio output mux and the PCM-to-I2S
// converter. Independent left/right strobes are paired into frames, stored
// in a DEPTH-frame ring, and handed out one frame per rd_req once PREFILL
// frames have accumulated.
//
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   run        audio enable; low flushes the buffer and holds IDLE
//   clr_flags  clears the sticky overrun/underrun flags
//   audio      sample path interface (slave side)
//   level      frames currently stored, 0..DEPTH
//   streaming  high while the FSM is in STREAM
//   overrun    sticky, a completed frame was dropped because the buffer was full
//   underrun   sticky, rd_req found the buffer empty while streaming
// -----------------------------------------------------------------------------
module stereo_sample_fifo
    import stereo_sample_fifo_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8,
    parameter int DW      = AUDIO_DW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 clr_flags,
    stereo_sample_fifo_if.slave  audio,
    output logic [6:0]           level,
    output logic                 streaming,
    output logic                 overrun,
    output logic                 underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [6:0] LEVEL_FULL    = 7'(DEPTH);
    localparam logic [6:0] LEVEL_PREFILL = 7'(PREFILL);

    fifo_state_t    state;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           l_have;
    logic           r_have;
    logic [DW-1:0]  l_hold;
    logic [DW-1:0]  r_hold;
    logic           rd_gap;
    logic           out_zero;
    logic           dout_valid_q;
    logic [2*DW-1:0] ram_rd_data;

    logic           active;
    logic           frame_done;
    logic [DW-1:0]  frame_l;
    logic [DW-1:0]  frame_r;
    logic           rd_accept;
    logic           pop;
    logic           underflow;
    logic           wr_en;
    logic           drop;
    logic [6:0]     level_next;

    // Per-cycle decisions. Nothing is accepted in IDLE or in a cycle where
    // run is low, because that cycle ends in a flush anyway. A frame
    // completes when each channel is either already latched or strobing
    // now; a live strobe takes priority over the latched copy.
    always_comb begin
        active     = (state != ST_IDLE) && run;
        frame_done = active && (l_have || audio.l_din_valid) && (r_have || audio.r_din_valid);
        frame_l    = audio.l_din_valid ? audio.l_din : l_hold;
        frame_r    = audio.r_din_valid ? audio.r_din : r_hold;

        // rd_gap masks a request arriving right after an accepted one.
        rd_accept  = active && audio.rd_req && !rd_gap;
        pop        = rd_accept && (state == ST_STREAM) && (level != 7'd0);
        underflow  = rd_accept && (state == ST_STREAM) && (level == 7'd0);

        // A pop in the same cycle frees the slot the full-buffer write needs.
        wr_en      = frame_done && ((level != LEVEL_FULL) || pop);
        drop       = frame_done && (level == LEVEL_FULL) && !pop;

        level_next = level;
        if (wr_en && !pop) begin
            level_next = level + 7'd1;
        end else if (!wr_en && pop) begin
            level_next = level - 7'd1;
        end
    end

    stereo_frame_ram #(
        .DEPTH (DEPTH),
        .W     (2 * DW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({frame_l, frame_r}),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // FSM, pair latches, pointers, level and flags. Sticky flags sit outside
    // the run flush so the CPU still sees them after audio is stopped, and a
    // set in the same cycle as clr_flags wins. out_zero selects the zero
    // frame for PREFILL requests and underruns; it resets high so the
    // unreset RAM read register never reaches the outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            l_have       <= 1'b0;
            r_have       <= 1'b0;
            l_hold       <= '0;
            r_hold       <= '0;
            rd_gap       <= 1'b0;
            out_zero     <= 1'b1;
            dout_valid_q <= 1'b0;
            level        <= '0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            overrun  <= drop || (overrun && !clr_flags);
            underrun <= underflow || (underrun && !clr_flags);

            if (!run) begin
                state        <= ST_IDLE;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                l_have       <= 1'b0;
                r_have       <= 1'b0;
                rd_gap       <= 1'b0;
                dout_valid_q <= 1'b0;
                level        <= '0;
            end else begin
                rd_gap       <= rd_accept;
                dout_valid_q <= rd_accept;
                if (rd_accept) begin
                    out_zero <= !pop;
                end

                if (frame_done) begin
                    l_have <= 1'b0;
                    r_have <= 1'b0;
                end else if (active) begin
                    if (audio.l_din_valid) begin
                        l_have <= 1'b1;
                        l_hold <= audio.l_din;
                    end
                    if (audio.r_din_valid) begin
                        r_have <= 1'b1;
                        r_hold <= audio.r_din;
                    end
                end

                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                level <= level_next;

                case (state)
                    ST_IDLE: begin
                        state <= ST_PREFILL;
                    end
                    ST_PREFILL: begin
                        if (level >= LEVEL_PREFILL) begin
                            state <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (underflow) begin
                            state <= ST_PREFILL;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign streaming        = (state == ST_STREAM);
    assign audio.dout_valid = dout_valid_q;
    assign audio.l_dout     = out_zero ? '0 : ram_rd_data[2*DW-1:DW];
    assign audio.r_dout     = out_zero ? '0 : ram_rd_data[DW-1:0];

endmodule

// File: tb/tb_stereo_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_stereo_sample_fifo
//
// Directed bench for stereo_sample_fifo with DEPTH=16, PREFILL=8, DW=24.
// Inputs change 1 ns after the rising edge and outputs are read there too.
// -----------------------------------------------------------------------------
module tb_stereo_sample_fifo;
    import stereo_sample_fifo_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic       clr_flags;
    logic [6:0] level;
    logic       streaming;
    logic       overrun;
    logic       underrun;

    int checks;
    int passed;

    stereo_sample_fifo_if #(.DW(24)) bus ();

    stereo_sample_fifo #(
        .DEPTH   (16),
        .PREFILL (8),
        .DW      (24)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .clr_flags (clr_flags),
        .audio     (bus.slave),
        .level     (level),
        .streaming (streaming),
        .overrun   (overrun),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        bus.l_din = l;
        bus.r_din = r;
        bus.l_din_valid = 1'b1;
        bus.r_din_valid = 1'b1;
        tick(1);
        bus.l_din_valid = 1'b0;
        bus.r_din_valid = 1'b0;
    endtask

    task automatic strobe_l(input logic [23:0] l);
        bus.l_din = l;
        bus.l_din_valid = 1'b1;
        tick(1);
        bus.l_din_valid = 1'b0;
    endtask

    task automatic strobe_r(input logic [23:0] r);
        bus.r_din = r;
        bus.r_din_valid = 1'b1;
        tick(1);
        bus.r_din_valid = 1'b0;
    endtask

    // Leaves the dout of the request visible on return.
    task automatic read_frame();
        bus.rd_req = 1'b1;
        tick(1);
        bus.rd_req = 1'b0;
    endtask

    // Flush through IDLE, clear flags, and land in PREFILL.
    task automatic restart();
        run = 1'b0;
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        run = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(2);
        checks++; if (level !== 7'd0) $display("[TB] FAIL reset_level: got %0d expected 0", level); else passed++;
        checks++; if (streaming !== 1'b0) $display("[TB] FAIL reset_streaming: got %b expected 0", streaming); else passed++;
        checks++; if (bus.dout_valid !== 1'b0) $display("[TB] FAIL reset_dout_valid: got %b expected 0", bus.dout_valid); else passed++;
        checks++; if ({bus.l_dout, bus.r_dout} !== 48'h0) $display("[TB] FAIL reset_dout: got %h expected 0", {bus.l_dout, bus.r_dout}); else passed++;
        checks++; if ({overrun, underrun} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {overrun, underrun}); else passed++;
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_prefill_stream();
        restart();
        read_frame();
        checks++; if (bus.dout_valid !== 1'b1) $display("[TB] FAIL prefill_rd_valid: got %b expected 1", bus.dout_valid); else passed++;
        checks++; if ({bus.l_dout, bus.r_dout} !== 48'h0) $display("[TB] FAIL prefill_rd_zero: got %h expected 0", {bus.l_dout, bus.r_dout}); else passed++;
        tick(1);
        for (int i = 1; i <= 8; i++) send_frame(24'(i), 24'h800000 + 24'(i));
        checks++; if (level !== 7'd8) $display("[TB] FAIL prefill_level: got %0d expected 8", level); else passed++;
        checks++; if (streaming !== 1'b0) $display("[TB] FAIL prefill_not_yet_stream: got %b expected 0", streaming); else passed++;
        tick(1);
        checks++; if (streaming !== 1'b1) $display("[TB] FAIL prefill_to_stream: got %b expected 1", streaming); else passed++;
        for (int i = 1; i <= 3; i++) begin
            tick(63);
            read_frame();
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.l_dout !== 24'(i) || bus.r_dout !== 24'h800000 + 24'(i))
                $display("[TB] FAIL stream_pop%0d: got v=%b %h/%h expected v=1 %h/%h", i, bus.dout_valid, bus.l_dout, bus.r_dout, 24'(i), 24'h800000 + 24'(i));
            else passed++;
        end
        tick(1);
        checks++; if (bus.dout_valid !== 1'b0 || bus.l_dout !== 24'd3) $display("[TB] FAIL stream_hold: got v=%b l=%h expected v=0 l=3", bus.dout_valid, bus.l_dout); else passed++;
        checks++; if (level !== 7'd5) $display("[TB] FAIL stream_level: got %0d expected 5", level); else passed++;
    endtask

    task automatic test_pair_skew();
        restart();
        strobe_l(24'h000111);
        tick(4);
        checks++; if (level !== 7'd0) $display("[TB] FAIL skew_half_frame: got %0d expected 0", level); else passed++;
        strobe_l(24'h000222);
        strobe_r(24'h000333);
        checks++; if (level !== 7'd1) $display("[TB] FAIL skew_first_frame: got %0d expected 1", level); else passed++;
        send_frame(24'h000444, 24'h000555);
        checks++; if (level !== 7'd2) $display("[TB] FAIL skew_level2: got %0d expected 2", level); else passed++;
        for (int i = 0; i < 6; i++) send_frame(24'h00A000 + 24'(i), 24'h00B000 + 24'(i));
        tick(1);
        read_frame();
        checks++; if ({bus.l_dout, bus.r_dout} !== {24'h000222, 24'h000333}) $display("[TB] FAIL skew_newest_wins: got %h expected 000222000333", {bus.l_dout, bus.r_dout}); else passed++;
        tick(1);
        read_frame();
        checks++; if ({bus.l_dout, bus.r_dout} !== {24'h000444, 24'h000555}) $display("[TB] FAIL skew_same_cycle: got %h expected 000444000555", {bus.l_dout, bus.r_dout}); else passed++;
    endtask

    task automatic test_overrun();
        logic [23:0] exp_l;
        restart();
        for (int i = 1; i <= 16; i++) send_frame(24'(i), 24'h400000 + 24'(i));
        checks++; if (level !== 7'd16 || overrun !== 1'b0) $display("[TB] FAIL ovr_full: got level=%0d ovr=%b expected 16 0", level, overrun); else passed++;
        send_frame(24'h000099, 24'h000099);
        checks++; if (level !== 7'd16 || overrun !== 1'b1) $display("[TB] FAIL ovr_drop: got level=%0d ovr=%b expected 16 1", level, overrun); else passed++;
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); else passed++;
        // Write and pop together at full.
        bus.rd_req = 1'b1;
        send_frame(24'h0000AA, 24'h0000BB);
        bus.rd_req = 1'b0;
        checks++; if (level !== 7'd16 || overrun !== 1'b0) $display("[TB] FAIL ovr_simul: got level=%0d ovr=%b expected 16 0", level, overrun); else passed++;
        checks++; if (bus.l_dout !== 24'd1) $display("[TB] FAIL ovr_simul_data: got %h expected 1", bus.l_dout); else passed++;
        for (int i = 2; i <= 17; i++) begin
            tick(1);
            read_frame();
            exp_l = (i == 17) ? 24'h0000AA : 24'(i);
            checks++; if (bus.l_dout !== exp_l) $display("[TB] FAIL ovr_drain%0d: got %h expected %h", i, bus.l_dout, exp_l); else passed++;
        end
        checks++; if (level !== 7'd0) $display("[TB] FAIL ovr_drained: got %0d expected 0", level); else passed++;
    endtask

    task automatic test_underrun();
        restart();
        for (int i = 0; i < 8; i++) send_frame(24'h000700 + 24'(i), 24'h000800 + 24'(i));
        tick(1);
        for (int i = 0; i < 8; i++) begin
            read_frame();
            tick(1);
        end
        checks++; if (level !== 7'd0 || streaming !== 1'b1) $display("[TB] FAIL und_empty: got level=%0d str=%b expected 0 1", level, streaming); else passed++;
        read_frame();
        checks++; if (bus.dout_valid !== 1'b1 || {bus.l_dout, bus.r_dout} !== 48'h0) $display("[TB] FAIL und_zero_frame: got v=%b %h expected v=1 0", bus.dout_valid, {bus.l_dout, bus.r_dout}); else passed++;
        checks++; if (underrun !== 1'b1 || streaming !== 1'b0) $display("[TB] FAIL und_flag_state: got und=%b str=%b expected 1 0", underrun, streaming); else passed++;
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        checks++; if (underrun !== 1'b0) $display("[TB] FAIL und_clear: got %b expected 0", underrun); else passed++;
    endtask

    task automatic test_wrap();
        int w;
        int r;
        logic [23:0] exp_l;
        restart();
        for (w = 0; w < 8; w++) send_frame(24'h001000 + 24'(w), ~(24'h001000 + 24'(w)));
        tick(1);
        r = 0;
        for (int k = 0; k < 100; k++) begin
            bus.rd_req = 1'b1;
            send_frame(24'h001000 + 24'(w), ~(24'h001000 + 24'(w)));
            bus.rd_req = 1'b0;
            w++;
            exp_l = 24'h001000 + 24'(r);
            checks++;
            if (bus.l_dout !== exp_l || bus.r_dout !== ~exp_l)
                $display("[TB] FAIL wrap_data%0d: got %h/%h expected %h/%h", k, bus.l_dout, bus.r_dout, exp_l, ~exp_l);
            else passed++;
            r++;
            checks++; if (level < 7'd7 || level > 7'd9) $display("[TB] FAIL wrap_level%0d: got %0d expected 7..9", k, level); else passed++;
            tick(2);
        end
    endtask

    task automatic test_run_drop();
        restart();
        for (int i = 0; i < 8; i++) send_frame(24'h000300 + 24'(i), 24'h000400 + 24'(i));
        tick(1);
        for (int i = 0; i < 3; i++) begin
            read_frame();
            tick(1);
        end
        checks++; if (level !== 7'd5) $display("[TB] FAIL drop_level5: got %0d expected 5", level); else passed++;
        run = 1'b0;
        tick(1);
        checks++; if (level !== 7'd0 || streaming !== 1'b0) $display("[TB] FAIL drop_flush: got level=%0d str=%b expected 0 0", level, streaming); else passed++;
        run = 1'b1;
        tick(1);
        read_frame();
        checks++; if (streaming !== 1'b0 || {bus.l_dout, bus.r_dout} !== 48'h0) $display("[TB] FAIL drop_fresh_prefill: got str=%b %h expected 0 0", streaming, {bus.l_dout, bus.r_dout}); else passed++;
        for (int i = 0; i < 8; i++) send_frame(24'h000500 + 24'(i), 24'h000600 + 24'(i));
        tick(1);
        read_frame();
        checks++; if ({bus.l_dout, bus.r_dout} !== {24'h000500, 24'h000600}) $display("[TB] FAIL drop_new_data: got %h expected 000500000600", {bus.l_dout, bus.r_dout}); else passed++;
    endtask

    task automatic test_async_reset();
        restart();
        for (int i = 1; i <= 17; i++) send_frame(24'h00C000 + 24'(i), 24'h00D000 + 24'(i));
        tick(1);
        read_frame();
        checks++; if (bus.dout_valid !== 1'b1 || overrun !== 1'b1 || bus.l_dout !== 24'h00C001) $display("[TB] FAIL arst_setup: got v=%b ovr=%b l=%h expected 1 1 00C001", bus.dout_valid, overrun, bus.l_dout); else passed++;
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dout_valid !== 1'b0 || {bus.l_dout, bus.r_dout} !== 48'h0 || level !== 7'd0 || streaming !== 1'b0 || overrun !== 1'b0 || underrun !== 1'b0)
            $display("[TB] FAIL arst_outputs: got v=%b d=%h lvl=%0d str=%b ovr=%b und=%b expected all 0", bus.dout_valid, {bus.l_dout, bus.r_dout}, level, streaming, overrun, underrun);
        else passed++;
        #2;
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset_n = 1'b0;
        run = 1'b0;
        clr_flags = 1'b0;
        bus.l_din_valid = 1'b0;
        bus.r_din_valid = 1'b0;
        bus.l_din = '0;
        bus.r_din = '0;
        bus.rd_req = 1'b0;
        test_reset();
        test_prefill_stream();
        test_pair_skew();
        test_overrun();
        test_underrun();
        test_wrap();
        test_run_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stereo_sample_fifo.md
# stereo_sample_fifo

Elastic stereo sample buffer between the audio output mux and the PCM-to-I2S converter. It pairs the mux's independent left and right valid strobes into stereo frames and absorbs jitter between the processing-side sample rate and the DAC frame clock. The DAC side pulls one frame per request. Overrun, underrun and fill level are reported to the CPU status logic.

## Interface
- DEPTH, 16: frame capacity; a power of two, 4..64.
- PREFILL, 8: frames required before streaming starts; 1 ≤ PREFILL ≤ DEPTH.
- DW, 24: sample width.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- run  in  1  audio enable (audio_control[0]); 0 flushes the buffer and holds IDLE.
- clr_flags  in  1  strobe; clears the sticky flags.
- l_din_valid  in  1  strobe; l_din is valid.
- r_din_valid  in  1  strobe; r_din is valid.
- l_din  in  DW  left sample.
- r_din  in  DW  right sample.
- rd_req  in  1  strobe from the I2S side at each frame start.
- dout_valid  out  1  strobe; l_dout and r_dout are valid.
- l_dout  out  DW  left sample out.
- r_dout  out  DW  right sample out.
- level  out  7  frames stored, 0..DEPTH.
- streaming  out  1  FSM is in STREAM.
- overrun  out  1  sticky; a frame was dropped because the buffer was full.
- underrun  out  1  sticky; rd_req arrived while the buffer was empty in STREAM.

## Operation
- **Reset values:** every output is 0, pointers are 0, both pair latches are empty, FSM is IDLE.
- **Pair assembly:**
  - l_din_valid latches l_din and sets l_have; r_din_valid does the same for r_din and r_have.
  - A frame is written when both latches are full: both flags were set earlier, or one flag was set and the other strobe arrives, or both strobes arrive in the same cycle. Both flags clear in that cycle.
  - A repeated strobe on a channel whose latch is already full overwrites the latched sample. This is the newest-wins rule.
- **Write:**
  - If level < DEPTH, write the frame at wr_ptr and increment wr_ptr.
  - If level == DEPTH, drop the frame and set overrun.
- **FSM:**
  - IDLE: entered on run=0. Pointers and latches are flushed and rd_req is ignored. Goes to PREFILL when run=1.
  - PREFILL: writes are accepted. Each rd_req returns a zero frame with dout_valid. Goes to STREAM when level ≥ PREFILL.
  - STREAM, rd_req with level > 0: pop the frame at rd_ptr.
  - STREAM, rd_req with level == 0: output the zero frame, set underrun, go to PREFILL.
  - Any state: run=0 goes to IDLE the next cycle.
- **Simultaneous write and pop:** both happen in the same cycle and level is unchanged. When the buffer is full, a pop in the same cycle frees a slot, so the write is accepted. This applies at level == DEPTH only.
- **Pointer arithmetic:** pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is the true count, not derived from pointer difference.
- **Sticky flags:** clr_flags clears both. If a set condition occurs in the same cycle as clr_flags, the set wins.

## Timing
- rd_req in cycle N gives dout_valid=1 with l_dout and r_dout in cycle N+1, for one cycle. The data outputs hold until the next dout_valid.
- A frame completing in cycle N is counted in level at N+1 and is poppable by an rd_req in cycle N+1.
- rd_req strobes are at least 2 cycles apart; an rd_req that arrives earlier is ignored.
- The PREFILL→STREAM transition happens the cycle after level reaches PREFILL.
- When run falls, level, streaming and the pointers read 0 at N+1. The sticky flags are not cleared by run.
- Asynchronous reset mid-operation returns every output to its reset value immediately, with no partial frame emitted.

## Structure
- The shared audio package holds:
  - the `AUDIO_DW` constant (24);
  - the `stereo_frame_t` typedef, {left, right} of 2×DW;
  - the FSM state enum {IDLE, PREFILL, STREAM}.
- One sub-module, `stereo_frame_ram`: a simple dual-port DEPTH×(2·DW) memory with a synchronous registered read. It infers LUTRAM or BRAM.
- Pair assembly, pointers, the FSM and the flags live in the top module.

## Test plan
- **Prefill to stream:** run=1, write 8 frames (L=i, R=0x800000+i), then rd_req every 64 cycles.
  - The first poppable rd_req goes out with streaming=1 and returns L=1, R=0x800001; following pops return the frames in order.
  - rd_req issued while still in PREFILL return zero frames.
- **Pair skew:** l_din_valid alone, r_din_valid 5 cycles later, then both strobes in the same cycle.
  - Exactly 2 frames are written and level=2.
  - A repeated l strobe before its r strobe keeps the newest left sample.
- **Overrun:** fill 16 frames with no rd_req, then write a 17th.
  - level stays 16 and overrun=1.
  - A write and rd_req in the same cycle at full keeps level=16 and does not set the flag again.
- **Underrun:** in STREAM, drain to level 0, then issue rd_req.
  - The output is a zero frame, underrun=1, the FSM returns to PREFILL and streaming=0.
  - A clr_flags pulse clears underrun.
- **Wrap-around:** stream 100 frames with the write rate equal to the rd_req rate.
  - The output sequence matches the input with no loss and level stays between 7 and 9.
- **run drop and reset:** drop run mid-stream with level=5.
  - Next cycle level=0 and streaming=0.
  - Re-asserting run requires a fresh prefill.
  - Asserting reset_n=0 asynchronously zeroes every output.
